vc_qspi_mem: RTL and testbench
==============================

// Module: vc_qspi_mem
// PURPOSE
// - Physical-memory back end for the vc CPU: converts 16-bit CPU bus requests (22-bit PA) into
//   QPI transactions on the uio pins of the tt_um wrapper (QSPI Pmod pinout).
// - Sits directly downstream of the CPU/MMU and owns uio_out/uio_oe/uio_in.
// - PA[21]=0 selects flash on CS0, which is read-only. PA[21]=1 selects PSRAM on CS1.
// PARAMETERS
// - PA      22     physical address width; PA[PA-1] is the region select
// - DUMMY   6      dummy nibble cycles on reads, 1..15
// - RD_CMD  8'hEB  quad read command, sent as 2 nibbles
// - WR_CMD  8'h38  quad write command, sent as 2 nibbles
// PORTS
// - clk        in   1   system clock
// - reset      in   1   synchronous, active-high
// - req_valid  in   1   request present
// - req_ready  out  1   block can accept a request
// - req_write  in   1   1=write, 0=read
// - req_addr   in   PA  byte address; reads ignore bit 0
// - req_wmask  in   2   write byte lanes: 11=halfword, 01=byte at addr|0, 10=byte at addr|1
// - req_wdata  in   16  write data, little-endian lanes
// - rsp_valid  out  1   one-cycle completion pulse
// - rsp_err    out  1   qualified by rsp_valid; 1 = write to flash was rejected
// - rsp_rdata  out  16  read data, held until the next read completes
// - qspi_in    in   8   uio_in
// - qspi_out   out  8   uio_out: [0]CS0_n [1]SD0 [2]SD1 [3]SCK [4]SD2 [5]SD3 [6]CS1_n [7]CS2_n
// - qspi_oe    out  8   uio_oe
// BEHAVIOUR
// - Reset values:
//   - CS0_n, CS1_n and CS2_n are 1; SCK=0; SDx out=0.
//   - qspi_oe=8'b1100_1001, so data pins are inputs.
//   - req_ready=0 while reset is high. rsp_valid=0, rsp_err=0, rsp_rdata=0.
//   - State=IDLE.
// - States: IDLE -> CMD(2) -> ADDR(6) -> [DUMMY(DUMMY) -> RDATA(4)] | WDATA(N) -> DONE -> IDLE.
//   - Bracketed counts are nibble cycles; N=4 for a halfword write, N=2 for a byte write.
//   - One nibble cycle is 2 clk. Phase 0: SCK=0 and the new nibble is driven. Phase 1: SCK=1.
//   - Input nibble {SD3,SD2,SD1,SD0} is registered on the clk edge that ends phase 1.
// - Handshake:
//   - req_ready=1 only in IDLE; a request is accepted when req_valid & req_ready.
//   - All request fields are captured on acceptance; later input changes are ignored.
// - Selected CS_n goes low on the clk after acceptance and stays low for the whole
//   CMD..DATA span only.
//   - Read: CS low for exactly 2*(12+DUMMY) clk (36 at default).
//   - Write: CS low for exactly 2*(8+N) clk.
// - Address nibbles, MSB first: {3'b000, addr[PA-2:0]} (24 bits).
//   - Reads force bit 0 to 0.
//   - Byte writes use bit 0 = lane (wmask 10 -> 1).
// - Data nibble order: byte0[7:4], byte0[3:0], byte1[7:4], byte1[3:0].
//   - byte0 = data[7:0] and byte1 = data[15:8].
//   - A byte write sends only the selected lane.
// - SD0..SD3 oe=1 during CMD/ADDR/WDATA. oe=0 from the first DUMMY phase 0 through DONE.
// - DONE lasts 1 clk: all CS_n=1, SCK=0, rsp_valid=1, req_ready=0.
//   - On a read, rsp_rdata takes its new value in the same cycle.
//   - CS_n is therefore high for at least 2 clk between transactions.
// - Flash write (addr[PA-1]=0, write=1): no pin activity. Go to DONE next clk with rsp_err=1.
//   rsp_rdata is unchanged.
// - wmask=00 on a write: treated as a no-op write. DONE next clk, rsp_err=0, no pin activity.
// - CS2_n is held high always; its oe=1.
// - Reset asserted mid-transaction: on the next clk, all CS_n=1, SCK=0, data oe=0,
//   state=IDLE, and no rsp_valid is produced for the aborted request.
// - A request held on req_valid during reset is not accepted until the clk after
//   reset deasserts.
// TESTING
// - Read 0x000100, flash model returns 0x34,0x12.
//   -> Pins: CS0_n low 36 clk, nibbles E,B,0,0,0,1,0,0.
//   -> rsp_valid on clk 37 after accept, rsp_rdata=16'h1234, rsp_err=0.
// - Halfword write 0x200010 data 16'hBEEF, mask 11.
//   -> CS1_n low 24 clk, nibbles 3,8,0,0,0,0,1,0,E,F,B,E.
//   -> rsp_valid clk 25, PSRAM model holds EF,BE.
// - Byte write 0x200021 mask 10 data 16'hA5xx.
//   -> Address nibbles 0,0,0,0,2,1, data A,5, CS1_n low 20 clk.
//   -> Read-back of 0x200020 has byte1=0xA5.
// - Write to 0x000040.
//   -> No CS/SCK toggles, rsp_valid with rsp_err=1 two clk after accept.
// - Assert reset during ADDR nibble 3 of a read.
//   -> Next clk CS0_n=1, oe data=0, no rsp_valid, req_ready=1 one clk after reset drops.
// - Back-to-back reads with req_valid held high.
//   -> CS high gap exactly 2 clk, correct data for both, oe on data pins never 1 in DUMMY/RDATA.

Source files
------------

// File: rtl/vc_qspi_mem_if.sv
// CPU-side request/response bus of the vc physical-memory back end.
interface vc_qspi_mem_if #(
    parameter int unsigned PA = 22
) ();
    logic          req_valid;
    logic          req_ready;
    logic          req_write;
    logic [PA-1:0] req_addr;
    logic [1:0]    req_wmask;
    logic [15:0]   req_wdata;
    logic          rsp_valid;
    logic          rsp_err;
    logic [15:0]   rsp_rdata;

    modport master (
        output req_valid, req_write, req_addr, req_wmask, req_wdata,
        input  req_ready, rsp_valid, rsp_err, rsp_rdata
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wmask, req_wdata,
        output req_ready, rsp_valid, rsp_err, rsp_rdata
    );
endinterface

// File: rtl/vc_qspi_mem.sv
// QPI back end: turns 16-bit CPU requests into flash (CS0, read-only) or PSRAM (CS1)
// transactions on the QSPI Pmod uio pins. All pin and bus outputs are registered.
module vc_qspi_mem #(
    parameter int unsigned PA     = 22,
    parameter int unsigned DUMMY  = 6,
    parameter logic [7:0]  RD_CMD = 8'hEB,
    parameter logic [7:0]  WR_CMD = 8'h38
) (
    input  logic         clk,
    input  logic         reset,
    vc_qspi_mem_if.slave bus,
    input  logic [7:0]   qspi_in,
    output logic [7:0]   qspi_out,
    output logic [7:0]   qspi_oe
);
    localparam int unsigned AW       = 24;
    localparam logic [7:0]  OUT_IDLE = 8'hC1;
    localparam logic [7:0]  OE_IDLE  = 8'hC9;

    typedef enum logic [2:0] {
        S_IDLE, S_CMD, S_ADDR, S_DUMMY, S_RDATA, S_WDATA, S_SKIP, S_DONE
    } state_t;

    state_t        state, state_n;
    logic [3:0]    nib, nib_n, last_nib, nib_o;
    logic          ph, ph_n;
    logic          wr, wr_n;
    logic [PA-1:0] addr, addr_n;
    logic [1:0]    wmask, wmask_n;
    logic [15:0]   wdata, wdata_n;
    logic [11:0]   rd_sh, rd_sh_n;
    logic          ready, valid_n, err_q, err_n;
    logic          rsp_valid_q;
    logic [15:0]   rdata_q, rdata_n;
    logic [7:0]    out_n, oe_n, cmd, cmd_sh;
    logic [AW-1:0] addr_sh;
    logic [15:0]   wd_seq, wd_sh;
    logic          cs_low, drive, a0;
    logic [3:0]    qin_nib;

    assign qin_nib       = {qspi_in[5], qspi_in[4], qspi_in[2], qspi_in[1]};
    assign bus.req_ready = ready;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_err   = err_q;
    assign bus.rsp_rdata = rdata_q;

    // CS and non-data pins carry no input information.
    logic unused_qspi_in;
    assign unused_qspi_in = ^{qspi_in[7:6], qspi_in[3], qspi_in[0]};

    always_comb begin
        state_n  = state;
        nib_n    = nib;
        ph_n     = ph;
        wr_n     = wr;
        addr_n   = addr;
        wmask_n  = wmask;
        wdata_n  = wdata;
        rd_sh_n  = rd_sh;
        rdata_n  = rdata_q;
        err_n    = 1'b0;

        case (state)
            S_CMD:   last_nib = 4'd1;
            S_ADDR:  last_nib = 4'd5;
            S_DUMMY: last_nib = 4'(DUMMY - 1);
            S_RDATA: last_nib = 4'd3;
            S_WDATA: last_nib = (wmask == 2'b11) ? 4'd3 : 4'd1;
            default: last_nib = 4'd0;
        endcase

        case (state)
            S_IDLE: begin
                if (bus.req_valid && ready) begin
                    wr_n    = bus.req_write;
                    addr_n  = bus.req_addr;
                    wmask_n = bus.req_wmask;
                    wdata_n = bus.req_wdata;
                    nib_n   = 4'd0;
                    ph_n    = 1'b0;
                    // Flash writes and empty-mask writes never touch the pins.
                    if (bus.req_write && (!bus.req_addr[PA-1] || bus.req_wmask == 2'b00))
                        state_n = S_SKIP;
                    else
                        state_n = S_CMD;
                end
            end
            S_SKIP: begin
                state_n = S_DONE;
                err_n   = ~addr[PA-1];
            end
            S_DONE: state_n = S_IDLE;
            default: begin
                ph_n = ~ph;
                if (ph) begin
                    nib_n = nib + 4'd1;
                    if (state == S_RDATA) rd_sh_n = {rd_sh[7:0], qin_nib};
                    if (nib == last_nib) begin
                        nib_n = 4'd0;
                        case (state)
                            S_CMD:   state_n = S_ADDR;
                            S_ADDR:  state_n = wr ? S_WDATA : S_DUMMY;
                            S_DUMMY: state_n = S_RDATA;
                            default: state_n = S_DONE;
                        endcase
                        // Nibbles arrive b0[7:4], b0[3:0], b1[7:4], b1[3:0].
                        if (state == S_RDATA) rdata_n = {rd_sh[3:0], qin_nib, rd_sh[11:4]};
                    end
                end
            end
        endcase

        // Pin values for the coming cycle, derived from the next state.
        cs_low  = state_n inside {S_CMD, S_ADDR, S_DUMMY, S_RDATA, S_WDATA};
        drive   = state_n inside {S_CMD, S_ADDR, S_WDATA};
        cmd     = wr_n ? WR_CMD : RD_CMD;
        cmd_sh  = cmd << {nib_n, 2'b00};
        a0      = wr_n & ((wmask_n == 2'b11) ? addr_n[0] : wmask_n[1]);
        addr_sh = AW'({addr_n[PA-2:1], a0}) << {nib_n, 2'b00};
        wd_seq  = (wmask_n == 2'b11) ? {wdata_n[7:0], wdata_n[15:8]}
                : {(wmask_n[0] ? wdata_n[7:0] : wdata_n[15:8]), 8'h00};
        wd_sh   = wd_seq << {nib_n, 2'b00};

        case (state_n)
            S_CMD:   nib_o = cmd_sh[7:4];
            S_ADDR:  nib_o = addr_sh[AW-1 -: 4];
            S_WDATA: nib_o = wd_sh[15:12];
            default: nib_o = 4'h0;
        endcase

        out_n    = OUT_IDLE;
        out_n[0] = ~(cs_low & ~addr_n[PA-1]);
        out_n[6] = ~(cs_low & addr_n[PA-1]);
        out_n[3] = cs_low & ph_n;
        {out_n[5], out_n[4], out_n[2], out_n[1]} = nib_o;
        oe_n     = drive ? 8'hFF : OE_IDLE;
        valid_n  = (state_n == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            nib         <= 4'd0;
            ph          <= 1'b0;
            wr          <= 1'b0;
            addr        <= '0;
            wmask       <= 2'b00;
            wdata       <= 16'h0000;
            rd_sh       <= 12'h000;
            ready       <= 1'b0;
            rsp_valid_q <= 1'b0;
            err_q       <= 1'b0;
            rdata_q     <= 16'h0000;
            qspi_out    <= OUT_IDLE;
            qspi_oe     <= OE_IDLE;
        end else begin
            state       <= state_n;
            nib         <= nib_n;
            ph          <= ph_n;
            wr          <= wr_n;
            addr        <= addr_n;
            wmask       <= wmask_n;
            wdata       <= wdata_n;
            rd_sh       <= rd_sh_n;
            ready       <= (state_n == S_IDLE);
            rsp_valid_q <= valid_n;
            err_q       <= err_n;
            rdata_q     <= rdata_n;
            qspi_out    <= out_n;
            qspi_oe     <= oe_n;
        end
    end
endmodule

// File: tb/tb_vc_qspi_mem.sv
// Scoreboard bench for vc_qspi_mem with a pin-level QPI flash/PSRAM model.
module tb_vc_qspi_mem;
    localparam int unsigned PA    = 22;
    localparam int          DUMMY = 6;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] qspi_in, qspi_out, qspi_oe;

    vc_qspi_mem_if #(.PA(PA)) bus ();

    vc_qspi_mem #(.PA(PA), .DUMMY(DUMMY), .RD_CMD(8'hEB), .WR_CMD(8'h38)) dut (
        .clk(clk), .reset(reset), .bus(bus.slave),
        .qspi_in(qspi_in), .qspi_out(qspi_out), .qspi_oe(qspi_oe)
    );

    always #5 clk = ~clk;

    typedef struct { logic err; logic chk; logic [15:0] rdata; int lat; } rsp_t;
    typedef struct { logic cs1; int low; int nn; logic [63:0] nibs; } pin_t;
    rsp_t rsp_q[$];
    pin_t pin_q[$];

    int checks = 0;
    int fails  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- pin-level memory model ----------------
    logic [7:0] flash [int];
    logic [7:0] psram [int];
    wire        cs0 = qspi_out[0];
    wire        cs1 = qspi_out[6];
    wire        sck = qspi_out[3];
    wire [3:0]  onib   = {qspi_out[5], qspi_out[4], qspi_out[2], qspi_out[1]};
    wire [3:0]  doe    = {qspi_oe[5], qspi_oe[4], qspi_oe[2], qspi_oe[1]};
    logic [3:0] drv = 4'h0;
    assign qspi_in = {2'b00, drv[3], drv[2], 1'b0, drv[1], drv[0], 1'b0};

    int          r, rxn, low_cnt, oe_bad, gap_cnt, last_gap, cs_falls, sck_rises;
    logic [63:0] rx;
    logic        sel1, is_rd;
    logic [23:0] raddr;
    bit          txn_open = 1'b0;
    bit          abort_pin = 1'b0;

    function automatic logic [7:0] rd_byte(input logic s, input int a);
        if (s) return psram.exists(a) ? psram[a] : 8'h00;
        return flash.exists(a) ? flash[a] : 8'h00;
    endfunction

    initial begin
        cs_falls = 0; sck_rises = 0; gap_cnt = 0; last_gap = 0;
        r = 0; rxn = 0; rx = '0; low_cnt = 0; oe_bad = 0; sel1 = 0; is_rd = 0; raddr = '0;
    end

    always @(negedge cs0 or negedge cs1) begin
        cs_falls++;
        txn_open = 1'b1;
        sel1 = ~cs1;
        r = 0; rxn = 0; rx = '0; low_cnt = 0; oe_bad = 0; is_rd = 0; drv = 4'h0;
        last_gap = gap_cnt;
    end

    always @(posedge sck) begin
        int idx;
        logic [7:0] b;
        sck_rises++;
        if (qspi_oe[1]) begin rx = {rx[59:0], onib}; rxn++; end
        r++;
        if (r == 2) is_rd = (rx[7:0] == 8'hEB);
        if (r == 8) raddr = rx[23:0];
        idx = r - 1 - 8 - DUMMY;
        if (is_rd && idx >= 0 && idx < 4) begin
            b = rd_byte(sel1, int'(raddr) + idx / 2);
            drv = (idx % 2 == 0) ? b[7:4] : b[3:0];
        end else begin
            drv = 4'h0;
        end
    end

    always @(negedge clk) begin
        int cur;
        if (!cs0 || !cs1) begin
            low_cnt++;
            cur = sck ? r - 1 : r;
            if (doe !== ((is_rd && cur >= 8) ? 4'h0 : 4'hF)) oe_bad++;
            if (qspi_out[7] !== 1'b1 || qspi_oe[7] !== 1'b1 || (!cs0 && !cs1)) oe_bad++;
        end else begin
            gap_cnt++;
        end
    end

    always @(posedge cs0 or posedge cs1) begin
        pin_t e;
        logic [63:0] tmp;
        int a;
        if (txn_open) begin
            txn_open = 1'b0;
            gap_cnt = 0;
            drv = 4'h0;
            if (abort_pin) begin
                abort_pin = 1'b0;
            end else if (pin_q.size() == 0) begin
                check("unexpected_pins", 64'd1, 64'd0);
            end else begin
                e = pin_q.pop_front();
                check("pin_cs1", 64'(sel1), 64'(e.cs1));
                check("pin_low_clks", 64'(low_cnt), 64'(e.low));
                check("pin_nibble_count", 64'(rxn), 64'(e.nn));
                check("pin_nibbles", rx, e.nibs);
                check("pin_oe_errors", 64'(oe_bad), 64'd0);
                if (rxn >= 8) begin
                    tmp = rx << (64 - 4 * rxn);
                    if (tmp[63:56] == 8'h38) begin
                        a = int'(tmp[55:32]);
                        for (int k = 0; k < (rxn - 8) / 2; k++)
                            if (sel1) psram[a + k] = tmp[31 - 8 * k -: 8];
                            else      flash[a + k] = tmp[31 - 8 * k -: 8];
                    end
                end
            end
        end
    end

    // ---------------- response monitor ----------------
    int since_acc = 0;
    always @(negedge clk) begin
        rsp_t e;
        if (!reset) begin
            since_acc++;
            if (bus.rsp_valid) begin
                if (rsp_q.size() == 0) begin
                    check("unexpected_rsp", 64'd1, 64'd0);
                end else begin
                    e = rsp_q.pop_front();
                    check("rsp_err", 64'(bus.rsp_err), 64'(e.err));
                    if (e.chk) check("rsp_rdata", 64'(bus.rsp_rdata), 64'(e.rdata));
                    check("rsp_latency", 64'(since_acc), 64'(e.lat));
                end
            end
            if (bus.req_valid && bus.req_ready) since_acc = 0;
        end
    end

    // ---------------- stimulus ----------------
    task automatic exp_rsp(input logic err, input logic chk, input logic [15:0] d, input int lat);
        rsp_t e;
        e.err = err; e.chk = chk; e.rdata = d; e.lat = lat;
        rsp_q.push_back(e);
    endtask

    task automatic exp_pin(input logic s, input int low, input int nn, input logic [63:0] nibs);
        pin_t e;
        e.cs1 = s; e.low = low; e.nn = nn; e.nibs = nibs;
        pin_q.push_back(e);
    endtask

    task automatic issue(input logic w, input logic [21:0] a, input logic [1:0] m,
                         input logic [15:0] d, input logic keep);
        int n;
        n = 0;
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_write = w; bus.req_addr = a;
        bus.req_wmask = m; bus.req_wdata = d;
        while (!bus.req_ready && n < 200) begin @(negedge clk); n++; end
        if (!bus.req_ready) check("accept_timeout", 64'd0, 64'd1);
        @(posedge clk);
        #1;
        if (!keep) bus.req_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((rsp_q.size() != 0 || pin_q.size() != 0) && n < 500) begin @(negedge clk); n++; end
        if (rsp_q.size() != 0 || pin_q.size() != 0) begin
            check("drain_timeout", 64'(rsp_q.size() + pin_q.size()), 64'd0);
            rsp_q.delete();
            pin_q.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int cf, sr;
        bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_addr = '0;
        bus.req_wmask = 2'b00; bus.req_wdata = 16'h0000;
        flash[32'h100] = 8'h34;
        flash[32'h101] = 8'h12;

        repeat (3) @(negedge clk);
        check("rst_qspi_out", 64'(qspi_out), 64'hC1);
        check("rst_qspi_oe", 64'(qspi_oe), 64'hC9);
        check("rst_req_ready", 64'(bus.req_ready), 64'd0);
        check("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        check("rst_rsp_err", 64'(bus.rsp_err), 64'd0);
        check("rst_rsp_rdata", 64'(bus.rsp_rdata), 64'd0);
        reset = 1'b0;
        @(negedge clk);
        check("ready_after_reset", 64'(bus.req_ready), 64'd1);

        // Flash read.
        issue(1'b0, 22'h000100, 2'b11, 16'h0000, 1'b0);
        exp_pin(1'b0, 36, 8, 64'hEB000100);
        exp_rsp(1'b0, 1'b1, 16'h1234, 37);
        drain();

        // PSRAM halfword write.
        issue(1'b1, 22'h200010, 2'b11, 16'hBEEF, 1'b0);
        exp_pin(1'b1, 24, 12, 64'h38000010EFBE);
        exp_rsp(1'b0, 1'b0, 16'h0000, 25);
        drain();
        check("psram_0x10", 64'(rd_byte(1'b1, 32'h10)), 64'hEF);
        check("psram_0x11", 64'(rd_byte(1'b1, 32'h11)), 64'hBE);

        // Byte writes, upper and lower lane.
        issue(1'b1, 22'h200021, 2'b10, 16'hA533, 1'b0);
        exp_pin(1'b1, 20, 10, 64'h38000021A5);
        exp_rsp(1'b0, 1'b0, 16'h0000, 21);
        drain();
        issue(1'b1, 22'h200030, 2'b01, 16'h335A, 1'b0);
        exp_pin(1'b1, 20, 10, 64'h380000305A);
        exp_rsp(1'b0, 1'b0, 16'h0000, 21);
        drain();

        // Read-backs; odd address on a read is aligned down.
        issue(1'b0, 22'h200020, 2'b11, 16'h0000, 1'b0);
        exp_pin(1'b1, 36, 8, 64'hEB000020);
        exp_rsp(1'b0, 1'b1, 16'hA500, 37);
        drain();
        issue(1'b0, 22'h200031, 2'b11, 16'h0000, 1'b0);
        exp_pin(1'b1, 36, 8, 64'hEB000030);
        exp_rsp(1'b0, 1'b1, 16'h005A, 37);
        drain();
        issue(1'b0, 22'h200010, 2'b11, 16'h0000, 1'b0);
        exp_pin(1'b1, 36, 8, 64'hEB000010);
        exp_rsp(1'b0, 1'b1, 16'hBEEF, 37);
        drain();

        // Flash write rejected, mask-00 write ignored; neither toggles pins.
        cf = cs_falls; sr = sck_rises;
        issue(1'b1, 22'h000040, 2'b11, 16'h1111, 1'b0);
        exp_rsp(1'b1, 1'b1, 16'hBEEF, 2);
        drain();
        issue(1'b1, 22'h200050, 2'b00, 16'h2222, 1'b0);
        exp_rsp(1'b0, 1'b1, 16'hBEEF, 2);
        drain();
        check("nopin_cs_falls", 64'(cs_falls), 64'(cf));
        check("nopin_sck_rises", 64'(sck_rises), 64'(sr));

        // Reset during ADDR nibble 3 of a read.
        issue(1'b0, 22'h000100, 2'b11, 16'h0000, 1'b0);
        repeat (10) @(posedge clk);
        @(negedge clk);
        check("abort_cs0_low_before", 64'(cs0), 64'd0);
        abort_pin = 1'b1;
        reset = 1'b1;
        @(negedge clk);
        check("abort_cs0", 64'(cs0), 64'd1);
        check("abort_cs1", 64'(cs1), 64'd1);
        check("abort_sck", 64'(sck), 64'd0);
        check("abort_data_oe", 64'(doe), 64'd0);
        check("abort_ready", 64'(bus.req_ready), 64'd0);
        reset = 1'b0;
        @(negedge clk);
        check("abort_ready_after", 64'(bus.req_ready), 64'd1);
        repeat (40) @(negedge clk);

        // Back-to-back reads with req_valid held.
        issue(1'b0, 22'h000100, 2'b11, 16'h0000, 1'b1);
        exp_pin(1'b0, 36, 8, 64'hEB000100);
        exp_rsp(1'b0, 1'b1, 16'h1234, 37);
        issue(1'b0, 22'h200010, 2'b11, 16'h0000, 1'b0);
        exp_pin(1'b1, 36, 8, 64'hEB000010);
        exp_rsp(1'b0, 1'b1, 16'hBEEF, 37);
        drain();
        check("b2b_cs_gap", 64'(last_gap), 64'd2);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
